neuron_feeder: RTL and testbench

- Sequencer that drives one fully-connected layer's datapath (mux_x → accumulate → FP add bias → sigmoid).
- On start, walks every (neuron, input) pair. Issues synchronous reads to the pixel/activation, weight and bias memories. Emits a valid/ready stream of {pixel_bit, weight, bias, first, last, neuron_idx} to the neuron accumulator.
- Instantiated once per stage: stage 1 uses N_IN=784, N_OUT=400; stage 2 uses 400/400; stage 3 uses 400/10.

---
 rtl/neuron_feeder.sv | 224 ++++++++++++++++++++++
 tb/tb_neuron_feeder.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_feeder.sv
// neuron_feeder: sequencer for one fully-connected layer datapath.
// On start it walks every (neuron, input) pair in order and issues synchronous reads to
// the activation, weight and bias memories, which share one read strobe. Each returned
// element is streamed out with first/last/neuron tags over a valid/ready handshake.
//
// A 2-entry FIFO buffers returned data. The word returning from memory is presented
// directly when the FIFO is empty, which gives out_valid two cycles after start.
// Reads are credit-limited so the FIFO can never overflow.
//
// Optional feature: define STALL_CNT_EN to add stall_cycles_o. It counts the cycles with
// out_valid=1 and out_ready=0, saturates, and clears on reset and on an accepted start.
//
// Ports:
//   clk_i, reset_i       clock; synchronous active-high reset
//   start_i              begin a pass; ignored while busy_o=1
//   busy_o, done_o       pass in progress; one-cycle pulse once the last element is taken
//   pix_addr_o/rdata_i   activation memory read port (1-cycle latency)
//   w_addr_o/rdata_i     weight memory read port, address = neuron*N_IN + input
//   b_addr_o/rdata_i     bias memory read port, address = neuron
//   rd_en_o              read strobe common to all three memories
//   out_*                element stream towards the neuron accumulator
//   stall_cycles_o       output stall counter (STALL_CNT_EN only)
module neuron_feeder #(
  parameter int unsigned N_IN    = 784,
  parameter int unsigned N_OUT   = 400,
  parameter int unsigned W_WIDTH = 32,
  parameter int unsigned IN_AW   = 10,
  parameter int unsigned OUT_AW  = 9,
  parameter int unsigned W_AW    = 19
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [IN_AW-1:0]   pix_addr_o,
  input  logic               pix_rdata_i,
  output logic [W_AW-1:0]    w_addr_o,
  input  logic [W_WIDTH-1:0] w_rdata_i,
  output logic [OUT_AW-1:0]  b_addr_o,
  input  logic [W_WIDTH-1:0] b_rdata_i,
  output logic               rd_en_o,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic               out_pixel_o,
  output logic [W_WIDTH-1:0] out_weight_o,
  output logic [W_WIDTH-1:0] out_bias_o,
  output logic               out_first_o,
  output logic               out_last_o,
  output logic [OUT_AW-1:0]  out_neuron_o
`ifdef STALL_CNT_EN
  ,
  output logic [31:0]        stall_cycles_o
`endif
);

  localparam logic [IN_AW-1:0]  InLast  = IN_AW'(N_IN - 1);
  localparam logic [OUT_AW-1:0] OutLast = OUT_AW'(N_OUT - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  typedef struct packed {
    logic               pixel;
    logic [W_WIDTH-1:0] weight;
    logic [W_WIDTH-1:0] bias;
    logic               first;
    logic               last;
    logic [OUT_AW-1:0]  neuron;
  } entry_t;

  state_e             state_q, state_d;
  logic [IN_AW-1:0]   in_idx_q, in_idx_d;
  logic [OUT_AW-1:0]  n_idx_q, n_idx_d;
  logic [W_AW-1:0]    w_lin_q, w_lin_d;

  // Tags travel one cycle behind the read so they line up with the returning data.
  logic               inflight_q;
  logic               tag_first_q, tag_last_q;
  logic [OUT_AW-1:0]  tag_neuron_q;

  entry_t             fifo_q [2];
  logic               wr_ptr_q, rd_ptr_q;
  logic [1:0]         count_q, count_d;

  logic               fifo_empty, out_valid, pop, push, fifo_rd, rd_en, done;
  logic [2:0]         occupancy;
  entry_t             arrive, head;

  // Datapath / FIFO bookkeeping
  always_comb begin
    fifo_empty = (count_q == 2'd0);
    out_valid  = !fifo_empty || inflight_q;
    arrive     = '{pixel:  pix_rdata_i,
                   weight: w_rdata_i,
                   bias:   b_rdata_i,
                   first:  tag_first_q,
                   last:   tag_last_q,
                   neuron: tag_neuron_q};
    head       = fifo_empty ? arrive : fifo_q[rd_ptr_q];
    pop        = out_valid && out_ready_i;
    // Arriving word bypasses storage only when the FIFO is empty and it is taken now.
    push       = inflight_q && !(pop && fifo_empty);
    fifo_rd    = pop && !fifo_empty;
    count_d    = count_q + 2'(push) - 2'(fifo_rd);
    // Slots committed after this cycle, before a new read is granted.
    occupancy  = 3'(count_q) + 3'(inflight_q) - 3'(pop);
  end

  // Sequencer FSM
  always_comb begin
    state_d  = state_q;
    in_idx_d = in_idx_q;
    n_idx_d  = n_idx_q;
    w_lin_d  = w_lin_q;
    rd_en    = 1'b0;
    done     = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          in_idx_d = '0;
          n_idx_d  = '0;
          w_lin_d  = '0;
          state_d  = StIssue;
        end
      end
      StIssue: begin
        if (occupancy < 3'd2) begin
          rd_en = 1'b1;
          if (in_idx_q == InLast) begin
            in_idx_d = '0;
            if (n_idx_q == OutLast) begin
              // Final read issued: park counters so addresses idle at 0.
              n_idx_d = '0;
              w_lin_d = '0;
              state_d = StDrain;
            end else begin
              n_idx_d = n_idx_q + OUT_AW'(1);
              w_lin_d = w_lin_q + W_AW'(1);
            end
          end else begin
            in_idx_d = in_idx_q + IN_AW'(1);
            w_lin_d  = w_lin_q + W_AW'(1);
          end
        end
      end
      StDrain: begin
        // No reads are issued here, so an empty FIFO next cycle means everything is taken.
        if (count_d == 2'd0) state_d = StDone;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      in_idx_q     <= '0;
      n_idx_q      <= '0;
      w_lin_q      <= '0;
      inflight_q   <= 1'b0;
      tag_first_q  <= 1'b0;
      tag_last_q   <= 1'b0;
      tag_neuron_q <= '0;
      fifo_q[0]    <= '0;
      fifo_q[1]    <= '0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
    end else begin
      state_q      <= state_d;
      in_idx_q     <= in_idx_d;
      n_idx_q      <= n_idx_d;
      w_lin_q      <= w_lin_d;
      inflight_q   <= rd_en;
      tag_first_q  <= (in_idx_q == '0);
      tag_last_q   <= (in_idx_q == InLast);
      tag_neuron_q <= n_idx_q;
      if (push) begin
        fifo_q[wr_ptr_q] <= arrive;
        wr_ptr_q         <= !wr_ptr_q;
      end
      if (fifo_rd) rd_ptr_q <= !rd_ptr_q;
      count_q <= count_d;
    end
  end

`ifdef STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stall_q <= '0;
    end else if (state_q == StIdle && start_i) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready_i && stall_q != 32'hFFFF_FFFF) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles_o = stall_q;
`endif

  // Outputs; data fields read as zero whenever nothing is valid.
  always_comb begin
    busy_o       = (state_q != StIdle);
    done_o       = done;
    rd_en_o      = rd_en;
    pix_addr_o   = in_idx_q;
    b_addr_o     = n_idx_q;
    w_addr_o     = w_lin_q;
    out_valid_o  = out_valid;
    out_pixel_o  = out_valid ? head.pixel  : 1'b0;
    out_weight_o = out_valid ? head.weight : '0;
    out_bias_o   = out_valid ? head.bias   : '0;
    out_first_o  = out_valid ? head.first  : 1'b0;
    out_last_o   = out_valid ? head.last   : 1'b0;
    out_neuron_o = out_valid ? head.neuron : '0;
  end

endmodule

// File: tb/tb_neuron_feeder.sv
module tb_neuron_feeder;
  localparam int NI = 4;
  localparam int NO = 2;
  localparam int IA = 2;
  localparam int OA = 1;
  localparam int WA = 3;
  localparam int WW = 32;

  logic          clk = 1'b0;
  logic          reset, start, out_ready;
  logic          busy, done, rd_en, out_valid, out_pixel, out_first, out_last;
  logic [IA-1:0] pix_addr;
  logic [WA-1:0] w_addr;
  logic [OA-1:0] b_addr, out_neuron;
  logic          pix_rdata;
  logic [WW-1:0] w_rdata, b_rdata, out_weight, out_bias;
`ifdef STALL_CNT_EN
  logic [31:0]   stall_cycles;
`endif

  always #5 clk = !clk;

  neuron_feeder #(
    .N_IN(NI), .N_OUT(NO), .W_WIDTH(WW), .IN_AW(IA), .OUT_AW(OA), .W_AW(WA)
  ) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .busy_o(busy), .done_o(done),
    .pix_addr_o(pix_addr), .pix_rdata_i(pix_rdata), .w_addr_o(w_addr), .w_rdata_i(w_rdata),
    .b_addr_o(b_addr), .b_rdata_i(b_rdata), .rd_en_o(rd_en), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .out_pixel_o(out_pixel), .out_weight_o(out_weight),
    .out_bias_o(out_bias), .out_first_o(out_first), .out_last_o(out_last),
    .out_neuron_o(out_neuron)
`ifdef STALL_CNT_EN
    , .stall_cycles_o(stall_cycles)
`endif
  );

  // Synchronous-read memories
  logic          pix_mem [NI];
  logic [WW-1:0] w_mem [NI*NO];
  logic [WW-1:0] b_mem [NO];

  always @(posedge clk) begin
    if (rd_en) begin
      pix_rdata <= pix_mem[pix_addr];
      w_rdata   <= w_mem[w_addr];
      b_rdata   <= b_mem[b_addr];
    end
  end

  typedef struct packed {
    logic          pixel;
    logic [WW-1:0] weight;
    logic [WW-1:0] bias;
    logic          first;
    logic          last;
    logic [OA-1:0] neuron;
  } elem_t;

  elem_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference: the layer visits neuron-major, input-minor pairs.
  function automatic void build_expected();
    elem_t e;
    exp_q.delete();
    for (int n = 0; n < NO; n++) begin
      for (int i = 0; i < NI; i++) begin
        e.pixel  = pix_mem[i];
        e.weight = w_mem[n*NI + i];
        e.bias   = b_mem[n];
        e.first  = (i == 0);
        e.last   = (i == NI - 1);
        e.neuron = OA'(n);
        exp_q.push_back(e);
      end
    end
  endfunction

  task automatic randomize_mems();
    for (int i = 0; i < NI; i++) pix_mem[i] = 1'($urandom_range(1));
    for (int i = 0; i < NI*NO; i++) w_mem[i] = $urandom;
    for (int i = 0; i < NO; i++) b_mem[i] = $urandom;
  endtask

  // One full pass from a start pulse; cyc 0 is the first cycle after start is sampled.
  task automatic run_pass(input int ready_pct, input bit stall_mode, input bit poke_start,
                          output int first_acc, output int last_acc, output int n_stall);
    elem_t obs, prev, want;
    int issued, accepted, done_cnt, done_cyc;
    bit held, pop;
    issued = 0; accepted = 0; done_cnt = 0; done_cyc = -1; held = 0;
    first_acc = -1; last_acc = -1; n_stall = 0; prev = '0;
    build_expected();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc > 0) @(negedge clk);
      start     = poke_start && (cyc == 3);
      out_ready = stall_mode ? !(cyc >= 2 && cyc <= 6) : ($urandom_range(99) < ready_pct);
      #1;
      obs = '{out_pixel, out_weight, out_bias, out_first, out_last, out_neuron};
      pop = out_valid && out_ready;
      if (held) begin
        checks++;
        if (out_valid !== 1'b1 || obs !== prev)
          begin errors++; $display("FAIL stable cyc %0d got v=%b %h want v=1 %h", cyc, out_valid, obs, prev); end
      end
      if (rd_en === 1'b1) begin
        checks++;
        if (issued - accepted - int'(pop) >= 2 || issued >= NI*NO)
          begin errors++; $display("FAIL credit cyc %0d outstanding %0d issued %0d want <2 and <%0d", cyc, issued - accepted, issued, NI*NO); end
        issued++;
      end
      if (out_valid && !out_ready) n_stall++;
      if (pop) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL extra_elem cyc %0d got %h want none", cyc, obs);
        end else begin
          want = exp_q.pop_front();
          if (obs !== want)
            begin errors++; $display("FAIL elem[%0d] got %h want %h", accepted, obs, want); end
        end
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
        accepted++;
      end
      if (done_cyc < 0) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy cyc %0d got %b want 1", cyc, busy); end
      end else begin
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0)
          begin errors++; $display("FAIL idle cyc %0d got busy=%b valid=%b want 0 0", cyc, busy, out_valid); end
      end
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          checks++;
          if (cyc != last_acc + 1 || accepted != NI*NO)
            begin errors++; $display("FAIL done_timing got cyc %0d acc %0d want cyc %0d acc %0d", cyc, accepted, last_acc + 1, NI*NO); end
          if (poke_start) start = 1'b1;  // lands on the DONE cycle edge
        end
      end
      held = out_valid && !out_ready;
      prev = obs;
      if (done_cyc >= 0 && cyc == done_cyc + 4) break;
    end
    start = 1'b0;
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL done_count got %0d want 1", done_cnt); end
    checks++;
    if (accepted != NI*NO) begin errors++; $display("FAIL accepted got %0d want %0d", accepted, NI*NO); end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || rd_en !== 1'b0 || out_valid !== 1'b0)
      begin errors++; $display("FAIL reset_ctrl got %b%b%b%b want 0000", busy, done, rd_en, out_valid); end
    checks++;
    if (pix_addr !== '0 || w_addr !== '0 || b_addr !== '0)
      begin errors++; $display("FAIL reset_addr got %h %h %h want 0 0 0", pix_addr, w_addr, b_addr); end
    checks++;
    if (out_weight !== '0 || out_bias !== '0 || out_pixel !== 1'b0 || out_first !== 1'b0 ||
        out_last !== 1'b0 || out_neuron !== '0)
      begin errors++; $display("FAIL reset_data got %h %h want 0 0", out_weight, out_bias); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int fa, la, ns;
    for (int i = 0; i < NI*NO; i++) w_mem[i] = WW'(i + 1);
    b_mem[0] = 32'hAA; b_mem[1] = 32'hBB;
    pix_mem[0] = 1'b1; pix_mem[1] = 1'b0; pix_mem[2] = 1'b1; pix_mem[3] = 1'b0;
    run_pass(100, 1'b0, 1'b0, fa, la, ns);
    checks++;
    if (fa != 1 || la != 8)
      begin errors++; $display("FAIL basic_consecutive got %0d..%0d want 1..8", fa, la); end
  endtask

  task automatic test_latency();
    @(negedge clk); start = 1'b1; out_ready = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL lat_busy_T got %b want 0", busy); end
    @(negedge clk); start = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b1 || rd_en !== 1'b1 || out_valid !== 1'b0)
      begin errors++; $display("FAIL lat_T1 got busy=%b rd=%b v=%b want 1 1 0", busy, rd_en, out_valid); end
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL lat_T2 got v=%b want 1", out_valid); end
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_backpressure();
    int fa, la, ns;
    for (int p = 0; p < 4; p++) begin
      randomize_mems();
      run_pass((p == 3) ? 25 : 50, 1'b0, 1'b0, fa, la, ns);
    end
  endtask

  task automatic test_reset_mid();
    int acc, fa, la, ns;
    acc = 0;
    randomize_mems();
    @(negedge clk); start = 1'b1; out_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < 20 && acc < 3; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (out_valid && out_ready) acc++;
    end
    @(negedge clk); reset = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || rd_en !== 1'b0)
      begin errors++; $display("FAIL midreset_ctrl got v=%b busy=%b rd=%b want 0 0 0", out_valid, busy, rd_en); end
    checks++;
    if (pix_addr !== '0 || w_addr !== '0 || b_addr !== '0)
      begin errors++; $display("FAIL midreset_addr got %h %h %h want 0 0 0", pix_addr, w_addr, b_addr); end
    reset = 1'b0;
    run_pass(100, 1'b0, 1'b0, fa, la, ns);
  endtask

  task automatic test_start_ignored();
    int fa, la, ns;
    randomize_mems();
    run_pass(70, 1'b0, 1'b1, fa, la, ns);
  endtask

`ifdef STALL_CNT_EN
  task automatic test_stall_cnt();
    int fa, la, ns;
    randomize_mems();
    run_pass(0, 1'b1, 1'b0, fa, la, ns);
    checks++;
    if (stall_cycles !== 32'd5) begin errors++; $display("FAIL stall_after_done got %0d want 5", stall_cycles); end
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    #1;
    checks++;
    if (stall_cycles !== 32'd0) begin errors++; $display("FAIL stall_clear got %0d want 0", stall_cycles); end
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask
`endif

  initial begin
    reset = 1'b1; start = 1'b0; out_ready = 1'b0;
    pix_rdata = 1'b0; w_rdata = '0; b_rdata = '0;
    randomize_mems();
    test_reset();
    test_basic();
    test_latency();
    test_backpressure();
    test_reset_mid();
    test_start_ignored();
`ifdef STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
